dmem_port: RTL and testbench

//  Data-memory request port directly downstream of the store-lane placement stage.

---
 rtl/dmem_port.sv | 173 +++++++++++++++++
 tb/tb_dmem_port.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - LSU data-memory port: ctrl-to-strobe decode, req/gnt/rvalid bus, one outstanding access
// Optional WAIT timeout enabled by defining DMEM_TIMEOUT_EN.
module dmem_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_ctrl,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [3:0]  dec_be;
  logic        dec_ok;
  logic        tmo_hit;

  // funct3[2] only marks unsigned loads, so strobes depend on funct3[1:0] alone
  always_comb begin
    dec_be = 4'b0000;
    dec_ok = 1'b0;
    case (req_ctrl[3:2])
      2'b00: begin
        dec_be = 4'b0001 << req_ctrl[1:0];
        dec_ok = 1'b1;
      end
      2'b01: begin
        if (req_ctrl[1:0] == 2'b00) begin
          dec_be = 4'b0011;
          dec_ok = 1'b1;
        end else if (req_ctrl[1:0] == 2'b10) begin
          dec_be = 4'b1100;
          dec_ok = 1'b1;
        end
      end
      2'b10: begin
        if (!req_ctrl[4] && req_ctrl[1:0] == 2'b00) begin
          dec_be = 4'b1111;
          dec_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          unused_ok;

  assign unused_ok = ^req_addr[1:0];
  assign tmo_hit   = (tmo_q == CW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_ok;

  assign unused_ok = ^req_addr[1:0] ^ (TIMEOUT == 0);
  assign tmo_hit   = 1'b0;
`endif

  // A response pulse still blocks acceptance so the next access starts a cycle after it
  assign req_ready = (state_q == IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = {req_addr[31:2], 2'b00};
          be_d    = dec_be;
          wdata_d = req_we ? req_wdata : 32'h0;
          if (dec_ok) begin
            state_d = REQ;
          end else begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : mem_rdata;
        end else if (tmo_hit) begin
          state_d     = ERR;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus outputs decode from state so an async reset drops mem_req immediately
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? addr_q : 32'h0;
  assign mem_be    = mem_req ? be_q : 4'h0;
  assign mem_wdata = mem_req ? wdata_q : 32'h0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - scoreboard bench for dmem_port
// Timeout scenario expectations follow DMEM_TIMEOUT_EN.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [4:0]  req_ctrl = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  dmem_port #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 33'(rsp_valid), 33'(0));
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("rsp_data_err", {rsp_err, rsp_rdata}, e);
      end
    end
  end

  // Returns at the negedge of the cycle after acceptance; n = cycles spent waiting for ready
  task automatic send(input logic we, input logic [31:0] addr, input logic [4:0] ctrl,
                      input logic [31:0] wd, output int n);
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_ctrl = ctrl; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 33'(n), 33'(0));
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_ctrl = '0; req_wdata = '0;
  endtask

  logic [4:0] bad_ctrl[4];
  int n;

  initial begin
    bad_ctrl[0] = 5'b001_01; bad_ctrl[1] = 5'b010_10;
    bad_ctrl[2] = 5'b011_00; bad_ctrl[3] = 5'b111_00;

    #12;
    check("rst_mem_req", 33'(mem_req), 33'(0));
    check("rst_rsp_valid", 33'(rsp_valid), 33'(0));
    check("rst_mem_be", 33'(mem_be), 33'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 33'(req_ready), 33'(1));

    // 1: SB to lane 3, immediate grant, response at N+3
    send(1'b1, 32'h0000_1003, 5'b000_11, 32'hAB00_0000, n);
    check("t1_mem_req", 33'(mem_req), 33'(1));
    check("t1_mem_be", 33'(mem_be), 33'(4'b1000));
    check("t1_mem_addr", 33'(mem_addr), 33'(32'h1000));
    check("t1_mem_we", 33'(mem_we), 33'(1));
    check("t1_mem_wdata", 33'(mem_wdata), 33'(32'hAB00_0000));
    check("t1_ready_busy", 33'(req_ready), 33'(0));
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("t1_req_dropped", 33'(mem_req), 33'(0));
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    sb_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t1_rsp_n3", 33'(rsp_valid), 33'(1));
    check("t1_ready_in_rsp", 33'(req_ready), 33'(0));

    // 2: LW with grant held off three cycles
    send(1'b0, 32'h0000_2000, 5'b010_00, 32'hFFFF_FFFF, n);
    for (int i = 0; i < 4; i++) begin
      check("t2_req_stable", {mem_req, mem_addr}, {1'b1, 32'h2000});
      check("t2_be", 33'(mem_be), 33'(4'b1111));
      check("t2_wdata_load", 33'(mem_wdata), 33'(0));
      if (i == 3) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    sb_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t2_rsp", 33'(rsp_valid), 33'(1));

    // 3: illegal controls never reach the bus and error one cycle after accept
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back({1'b1, 32'h0});
      send(1'b0, 32'h0000_3000, bad_ctrl[k], 32'h0, n);
      check("t3_no_mem_req", 33'(mem_req), 33'(0));
      check("t3_rsp_err", {rsp_valid, 32'(rsp_err)}, {1'b1, 32'h1});
      @(negedge clk);
      check("t3_pulse_one", 33'(rsp_valid), 33'(0));
      check("t3_no_mem_req2", 33'(mem_req), 33'(0));
    end

    // 4: reset during REQ drops mem_req at once, then reset during WAIT loses the response
    send(1'b1, 32'h0000_4000, 5'b010_00, 32'h5555_AAAA, n);
    check("t4_req", 33'(mem_req), 33'(1));
    #1 rst_n = 1'b0;
    #1 check("t4_async_drop", 33'(mem_req), 33'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 32'h0000_4000, 5'b010_00, 32'h5555_AAAA, n);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t4_rst_mem_req", 33'(mem_req), 33'(0));
    check("t4_rst_rsp", 33'(rsp_valid), 33'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t4_ready_after", 33'(req_ready), 33'(1));
    repeat (3) begin
      @(negedge clk);
      check("t4_stray_ignored", {rsp_valid, 31'(0), mem_req}, 33'(0));
    end

    // 5: no response ever arrives
    send(1'b0, 32'h0000_6000, 5'b010_00, 32'h0, n);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    sb_q.push_back({1'b1, 32'h0});
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_cycles", 33'(n), 33'(4));
    check("t5_timeout_err", 33'(rsp_err), 33'(1));
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t5_late_rvalid", 33'(rsp_valid), 33'(0));
    check("t5_ready", 33'(req_ready), 33'(1));
`else
    n = 0;
    repeat (100) begin
      if (rsp_valid) n++;
      @(negedge clk);
    end
    check("t5_no_rsp_100", 33'(n), 33'(0));
    check("t5_still_busy", {req_ready, 31'(0), mem_req}, 33'(0));
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    sb_q.push_back({1'b0, 32'h0BAD_F00D});
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t5_late_rsp", 33'(rsp_valid), 33'(1));
`endif

    // 6: SH then LBU back to back; second accept in the cycle after the first response
    send(1'b1, 32'h0000_5002, 5'b001_10, 32'h1234_0000, n);
    check("t6_sh_be", 33'(mem_be), 33'(4'b1100));
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0000;
    sb_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t6_rsp1", 33'(rsp_valid), 33'(1));
    check("t6_ready_in_rsp", 33'(req_ready), 33'(0));
    send(1'b0, 32'h0000_5001, 5'b100_01, 32'hFFFF_FFFF, n);
    check("t6_accept_wait", 33'(n), 33'(0));
    check("t6_lbu_be", 33'(mem_be), 33'(4'b0010));
    check("t6_lbu_addr", 33'(mem_addr), 33'(32'h5000));
    check("t6_lbu_wdata", 33'(mem_wdata), 33'(0));
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("t6_rvalid_in_req_ignored", 33'(rsp_valid), 33'(0));
    mem_rdata = 32'h0000_AB00;
    sb_q.push_back({1'b0, 32'h0000_AB00});
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("t6_rsp2", 33'(rsp_valid), 33'(1));

    repeat (3) @(negedge clk);
    check("sb_drained", 33'(sb_q.size()), 33'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
